// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: in-order instruction prefetcher feeding the RV32 core, flushed by redirects.
// Slots are reserved at issue time (buffered + outstanding <= DEPTH), so a response never finds the FIFO full.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, tgt;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, disc_q, disc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [31:0] word_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic gnt, rsp, drop, push, pop;
  assign tgt           = redirect_pc_i & ~32'h3;
  assign mem_req_o     = !rst && !redirect_i && ({1'b0, count_q} + {1'b0, outst_q} < CAP);
  assign mem_addr_o    = fetch_pc_q;
  assign instr_valid_o = count_q != '0;
  assign instr_o       = word_q[rd_q];
  assign instr_pc_o    = pc_q[rd_q];
  assign gnt           = mem_req_o && mem_gnt_i;
  assign rsp           = mem_rvalid_i && outst_q != '0;
  assign drop          = rsp && disc_q != '0;
  assign push          = rsp && !drop && !redirect_i;
  assign pop           = instr_valid_o && instr_ready_i && !redirect_i;
  always_comb begin
    fetch_pc_d = redirect_i ? tgt : gnt ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = redirect_i ? tgt : push ? resp_pc_q + 32'd4 : resp_pc_q;
    outst_d    = outst_q + CW'(gnt) - CW'(rsp);
    // every response still owed at a flush is stale, except one retiring this cycle
    disc_d     = redirect_i ? outst_q - CW'(rsp) : disc_q - CW'(drop);
    count_d    = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);
    rd_d       = redirect_i ? '0 : rd_q + AW'(pop);
    wr_d       = redirect_i ? '0 : wr_q + AW'(push);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if (push) begin
        word_q[wr_q] <= mem_rdata_i;
        pc_q[wr_q]   <= resp_pc_q;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of streaming, backpressure, redirects, grant stalls and async reset.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] K = 32'hA5A5_0000;
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] a; int due; } req_t;
  logic clk = 0, rst = 1;
  logic mem_req, mem_gnt = 1, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_rdata = 0;
  logic redirect = 0, instr_ready = 1, instr_valid;
  logic [31:0] redirect_pc = 0, instr, instr_pc;
  int total = 0, bad = 0, ecnt = 0, gcnt = 0, pcnt = 0, lat = 1;
  bit gnt_rand = 0, gnt_off = 0, stab_en = 0, found;
  logic p_req = 0, p_gnt = 0;
  logic [31:0] p_addr = 0;
  ent_t got[$];
  req_t mq[$];
  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .instr_valid_o(instr_valid), .instr_o(instr),
    .instr_pc_o(instr_pc), .instr_ready_i(instr_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] g, input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, g, e);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic chk_seq(input logic [31:0] base, input int n);
    check("seq_len", 32'(got.size() >= n), 32'd1);
    for (int i = 0; i < got.size() && i < n; i++) begin
      check("seq_pc", got[i].pc, base + 32'(4 * i));
      check("seq_ins", got[i].ins, (base + 32'(4 * i)) ^ K);
    end
  endtask
  always @(posedge clk) begin
    req_t r;
    ecnt++;
    if (stab_en) begin
      if (p_req && !p_gnt && mem_req) check("addr_hold", mem_addr, p_addr);
      check("outst_max", 32'((mq.size() + int'(mem_rvalid)) <= DEPTH), 32'd1);
    end
    p_req = mem_req;
    p_gnt = mem_gnt;
    p_addr = mem_addr;
    if (mem_req && mem_gnt) begin
      r.a = mem_addr;
      r.due = ecnt + lat - 1;
      mq.push_back(r);
      gcnt++;
    end
    if (instr_valid && instr_ready && !redirect && !rst) begin
      got.push_back({instr_pc, instr});
      pcnt++;
    end
  end
  always @(negedge clk) begin
    mem_gnt = gnt_off ? 1'b0 : gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mq.size() > 0 && mq[0].due <= ecnt) begin
      mem_rvalid = 1;
      mem_rdata = mq[0].a ^ K;
      void'(mq.pop_front());
    end else begin
      mem_rvalid = 0;
      mem_rdata = 0;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end
  initial begin
    tick; tick; #1;
    check("rst_req", 32'(mem_req), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    tick; rst = 0; got.delete(); #1;
    check("c0_req", 32'(mem_req), 1);
    check("c0_addr", mem_addr, 0);
    tick; #1;
    check("c1_valid", 32'(instr_valid), 0);
    tick; #1;
    check("c2_valid", 32'(instr_valid), 1);
    check("c2_pc", instr_pc, 0);
    check("c2_ins", instr, K);
    for (int k = 1; k <= 9; k++) begin
      tick; #1;
      check("str_pc", instr_pc, 32'(4 * k));
      check("str_ins", instr, 32'(4 * k) ^ K);
    end
    tick; instr_ready = 0; #1;
    check("bp_pc0", instr_pc, 32'd40);
    repeat (10) tick;
    #1;
    check("bp_valid", 32'(instr_valid), 1);
    check("bp_hold", instr_pc, 32'd40);
    check("bp_req", 32'(mem_req), 0);
    check("bp_addr", mem_addr, 32'd56);
    check("bp_slots", 32'(gcnt - pcnt), DEPTH);
    instr_ready = 1;
    #1 check("bp_req_rel", 32'(mem_req), 0);
    for (int k = 1; k <= 7; k++) begin
      tick; #1;
      if (k == 1) begin
        check("bp_req_back", 32'(mem_req), 1);
        check("bp_addr_back", mem_addr, 32'd56);
      end
      check("bp_pc", instr_pc, 32'd40 + 32'(4 * k));
    end
    lat = 3;
    repeat (3) tick;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick;
      if (mq.size() + int'(mem_rvalid) >= 3) found = 1;
    end
    check("rd3_wait", 32'(found), 1);
    redirect = 1; redirect_pc = 32'h100; got.delete(); #1;
    check("rd_req", 32'(mem_req), 0);
    tick; redirect = 0; #1;
    check("rd_valid", 32'(instr_valid), 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick; #1;
      if (instr_valid) found = 1;
    end
    check("rd_wait", 32'(found), 1);
    check("rd_pc", instr_pc, 32'h100);
    repeat (10) tick;
    chk_seq(32'h100, 4);
    lat = 1;
    repeat (10) tick;
    #1 check("bb_pre_valid", 32'(instr_valid), 1);
    redirect = 1; redirect_pc = 32'h200; got.delete();
    tick; redirect_pc = 32'h306; #1;
    check("bb_req", 32'(mem_req), 0);
    tick; redirect = 0; #1;
    check("bb_v1", 32'(instr_valid), 0);
    check("bb_req1", 32'(mem_req), 1);
    check("bb_addr1", mem_addr, 32'h304);
    tick; #1;
    check("bb_v2", 32'(instr_valid), 0);
    tick; #1;
    check("bb_v3", 32'(instr_valid), 1);
    check("bb_pc3", instr_pc, 32'h304);
    repeat (8) tick;
    chk_seq(32'h304, 6);
    tick; redirect = 1; redirect_pc = 32'h400; got.delete();
    tick; redirect = 0; stab_en = 1; gnt_rand = 1;
    repeat (60) tick;
    chk_seq(32'h400, 15);
    stab_en = 0; gnt_rand = 0; lat = 3;
    tick; redirect = 1; redirect_pc = 32'hFFFF_FFF0; got.delete();
    tick; redirect = 0;
    repeat (14) tick;
    chk_seq(32'hFFFF_FFF0, 6);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick;
      if (mq.size() + int'(mem_rvalid) >= 2) found = 1;
    end
    check("ar_wait", 32'(found), 1);
    rst = 1; gnt_off = 1; #1;
    check("ar_req", 32'(mem_req), 0);
    check("ar_addr", mem_addr, 0);
    check("ar_valid", 32'(instr_valid), 0);
    check("ar_instr", instr, 0);
    check("ar_pc", instr_pc, 0);
    tick; rst = 0; got.delete(); #1;
    check("ar_rel_req", 32'(mem_req), 1);
    check("ar_rel_addr", mem_addr, 0);
    repeat (4) begin
      tick; #1;
      check("ar_gap", 32'(instr_valid), 0);
    end
    gnt_off = 0;
    repeat (15) tick;
    chk_seq(32'h0, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
